// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared constants and types for the FIFO read-side drain
// Holds the default data width, the output buffer depth and the buffer count/pointer types.
package fifo_drain_pkg;

  localparam int DW_DEFAULT = 8;
  localparam int BUF_DEPTH  = 2;

  // Occupancy of the 2-entry output buffer, 0..2.
  typedef logic [1:0] buf_cnt_t;
  // Head/tail index into the 2-entry output buffer.
  typedef logic       buf_ptr_t;

endpackage

// File: rtl/fifo_drain_buf.sv
// rtl/fifo_drain_buf.sv - 2-entry ring buffer behind the FIFO read port
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointers and count only)
//   wr, wr_data capture one entry at tail
//   rd          release the entry at head
//   rd_data     entry at head
//   count       current occupancy, 0..2
module fifo_drain_buf
  import fifo_drain_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd,
  output logic [DW-1:0] rd_data,
  output buf_cnt_t      count
);

  logic [DW-1:0] mem [BUF_DEPTH];
  buf_ptr_t      head;
  buf_ptr_t      tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (wr) tail <= ~tail;
      if (rd) head <= ~head;
      // Simultaneous write and read leave the occupancy unchanged.
      count <= count + buf_cnt_t'(wr) - buf_cnt_t'(rd);
    end
  end

  // Storage is deliberately left out of reset; count gates its visibility.
  always_ff @(posedge clk) begin
    if (wr) mem[tail] <= wr_data;
  end

  assign rd_data = mem[head];

endmodule

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - converts the FIFO read port into a valid/ready byte stream
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           drain enable; gates new pops only
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   FIFO read request (combinational)
//   fifo_data    FIFO registered read data, valid the cycle after a pop
//   m_valid, m_ready, m_data  output stream handshake and byte
//   idle         nothing buffered and nothing in flight
//   delivered    wrapping count of bytes accepted downstream
// Optional: define FIFO_DRAIN_ASSERT_EN to compile in clocked immediate assertions.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [DW-1:0]    fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic             idle,
  output logic [CNT_W-1:0] delivered
);

  logic     inflight;
  logic     pop;
  logic     deq;
  buf_cnt_t count;
  logic [2:0] occ_next;

  assign m_valid = (count != 2'd0);
  assign deq     = m_valid && m_ready;

  // Occupancy the buffer will hold after this edge, counting the byte already
  // in flight. Issuing only while it stays <= 1 leaves room for the new pop,
  // so the buffer can never overflow. The m_ready term keeps 1 byte/cycle.
  assign occ_next   = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
  assign fifo_rd_en = en && !fifo_empty && (occ_next <= 3'd1);
  assign pop        = fifo_rd_en && !fifo_empty;

  assign idle = (count == 2'd0) && !inflight;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      delivered <= '0;
    end else begin
      inflight <= pop;
      if (deq) delivered <= delivered + CNT_W'(1);
    end
  end

  // The FIFO presents the popped byte one cycle later; capture it then.
  fifo_drain_buf #(
    .DW(DW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (inflight),
    .wr_data (fifo_data),
    .rd      (deq),
    .rd_data (m_data),
    .count   (count)
  );

`ifdef FIFO_DRAIN_ASSERT_EN
  logic          stall_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
      data_q  <= '0;
    end else begin
      stall_q <= m_valid && !m_ready;
      data_q  <= m_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ((3'(count) + 3'(inflight)) <= 3'd2);
      assert (!(fifo_rd_en && fifo_empty));
      assert (m_valid == (count != 2'd0));
      if (stall_q) begin
        assert (m_valid && (m_data == data_q));
      end
    end
  end
`else
  // Assertions compiled out; functional logic above is unchanged.
`endif

endmodule
